apb_irq_ctrl: RTL and testbench



---
 rtl/apb_irq_ctrl_pkg.sv | 16 +
 rtl/irq_gateway.sv | 57 +++++
 rtl/apb_irq_ctrl.sv | 117 +++++++++++
 tb/tb_apb_irq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_irq_ctrl_pkg.sv
// apb_irq_ctrl_pkg
//   Shared constants for the APB interrupt controller: register byte
//   offsets and the architectural source-count limit.
package apb_irq_ctrl_pkg;

    localparam int unsigned OFS_PENDING = 'h000;
    localparam int unsigned OFS_ENABLE  = 'h004;
    localparam int unsigned OFS_TRIGGER = 'h008;
    localparam int unsigned OFS_CLAIM   = 'h00C;
    localparam int unsigned OFS_CTRL    = 'h010;

    // Source IDs are 1..MAX_SRC; ID 0 means "no source".
    localparam int unsigned MAX_SRC = 31;
    localparam int unsigned ID_W    = $clog2(MAX_SRC + 1);

endpackage

// File: rtl/irq_gateway.sv
// irq_gateway
//   Per-source interrupt gateway: registers the source line and keeps the
//   pending and in-service state for one interrupt source.
// Ports:
//   apb_pclk, apb_presetn : clock, asynchronous active-low reset
//   irq_line              : source interrupt line (synchronous, active-high)
//   trig_edge             : 1 = rising-edge trigger, 0 = level trigger
//   claim_clr             : claim read selected this source this cycle
//   complete              : complete write names this source this cycle
//   pending               : latched pending bit
module irq_gateway (
    input  logic apb_pclk,
    input  logic apb_presetn,
    input  logic irq_line,
    input  logic trig_edge,
    input  logic claim_clr,
    input  logic complete,
    output logic pending
);

    logic src_q;
    logic in_service;
    logic set_pend;

    // A level source being claimed this cycle is already in service from
    // the core's point of view, so it must not re-raise pending; an edge
    // arriving in the claim cycle is a new event and wins over the clear.
    always_comb begin
        set_pend = 1'b0;
        if (trig_edge) begin
            set_pend = irq_line & ~src_q;
        end else begin
            set_pend = irq_line & ~in_service & ~claim_clr;
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_presetn) begin
        if (!apb_presetn) begin
            src_q      <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            src_q <= irq_line;
            if (set_pend) begin
                pending <= 1'b1;
            end else if (claim_clr) begin
                pending <= 1'b0;
            end
            if (claim_clr) begin
                in_service <= 1'b1;
            end else if (complete && in_service) begin
                in_service <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl
//   APB-programmable interrupt controller. Collects N_SRC peripheral
//   interrupt lines, latches them into pending bits, and raises a single
//   registered request to the core. Software claims the lowest enabled
//   pending source via CLAIM reads and completes it via CLAIM writes.
// Ports:
//   apb_pclk, apb_presetn : clock, asynchronous active-low reset
//   apb_paddr/psel/penable/pwrite/pwdata : APB request (zero wait states)
//   apb_pready/prdata/pslverr            : APB response (combinational)
//   irq_src               : source lines, source k on irq_src[k-1]
//   irq_out               : registered interrupt request to the core
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned N_SRC          = 8
) (
    input  logic                      apb_pclk,
    input  logic                      apb_presetn,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic                      apb_pwrite,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
    output logic                      apb_pready,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata,
    output logic                      apb_pslverr,
    input  logic [N_SRC-1:0]          irq_src,
    output logic                      irq_out
);

    logic access, rd_en, wr_en, mapped;
    logic sel_pending, sel_enable, sel_trigger, sel_claim, sel_ctrl;
    logic [N_SRC-1:0] enable_q, trigger_q, pending, active;
    logic [N_SRC-1:0] claim_clr, complete;
    logic             ctrl_en_q;
    logic [ID_W-1:0]  claim_id;
    logic [APB_DATA_WIDTH-1:0] rd_mux;

    // Address decode: offsets are word aligned, so a full-address match
    // also rejects paddr[1:0] != 0.
    always_comb begin
        sel_pending = (apb_paddr == APB_ADDR_WIDTH'(OFS_PENDING));
        sel_enable  = (apb_paddr == APB_ADDR_WIDTH'(OFS_ENABLE));
        sel_trigger = (apb_paddr == APB_ADDR_WIDTH'(OFS_TRIGGER));
        sel_claim   = (apb_paddr == APB_ADDR_WIDTH'(OFS_CLAIM));
        sel_ctrl    = (apb_paddr == APB_ADDR_WIDTH'(OFS_CTRL));
        mapped      = sel_pending | sel_enable | sel_trigger | sel_claim | sel_ctrl;
        access      = apb_psel & apb_penable;
        rd_en       = access & ~apb_pwrite & mapped;
        wr_en       = access &  apb_pwrite & mapped;
    end

    assign apb_pready  = access;
    assign apb_pslverr = access & ~mapped;
    assign active      = pending & enable_q;

    // Lowest ID wins: scan from the top down so the last hit is the lowest.
    always_comb begin
        claim_id = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (active[i-1]) begin
                claim_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        claim_clr = '0;
        complete  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            claim_clr[i] = rd_en & sel_claim & (claim_id == ID_W'(i + 1));
            complete[i]  = wr_en & sel_claim & (apb_pwdata == APB_DATA_WIDTH'(i + 1));
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_en) begin
            if (sel_pending) rd_mux[N_SRC-1:0] = pending;
            if (sel_enable)  rd_mux[N_SRC-1:0] = enable_q;
            if (sel_trigger) rd_mux[N_SRC-1:0] = trigger_q;
            if (sel_claim)   rd_mux[ID_W-1:0]  = claim_id;
            if (sel_ctrl)    rd_mux[0]         = ctrl_en_q;
        end
    end

    assign apb_prdata = rd_mux;

    always_ff @(posedge apb_pclk or negedge apb_presetn) begin
        if (!apb_presetn) begin
            enable_q  <= '0;
            trigger_q <= '0;
            ctrl_en_q <= 1'b0;
            irq_out   <= 1'b0;
        end else begin
            if (wr_en && sel_enable)  enable_q  <= apb_pwdata[N_SRC-1:0];
            if (wr_en && sel_trigger) trigger_q <= apb_pwdata[N_SRC-1:0];
            if (wr_en && sel_ctrl)    ctrl_en_q <= apb_pwdata[0];
            irq_out <= ctrl_en_q & (|active);
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .apb_pclk    (apb_pclk),
            .apb_presetn (apb_presetn),
            .irq_line    (irq_src[g]),
            .trig_edge   (trigger_q[g]),
            .claim_clr   (claim_clr[g]),
            .complete    (complete[g]),
            .pending     (pending[g])
        );
    end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
module tb_apb_irq_ctrl;

    localparam int unsigned N_SRC = 8;

    logic        apb_pclk = 1'b0;
    logic        apb_presetn;
    logic [11:0] apb_paddr;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [31:0] apb_pwdata;
    logic        apb_pready;
    logic [31:0] apb_prdata;
    logic        apb_pslverr;
    logic [N_SRC-1:0] irq_src;
    logic        irq_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 apb_pclk = ~apb_pclk;

    apb_irq_ctrl #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(12), .N_SRC(N_SRC)) dut (
        .apb_pclk    (apb_pclk),
        .apb_presetn (apb_presetn),
        .apb_paddr   (apb_paddr),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_pready  (apb_pready),
        .apb_prdata  (apb_prdata),
        .apb_pslverr (apb_pslverr),
        .irq_src     (irq_src),
        .irq_out     (irq_out)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the commit edge.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output logic rdy);
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr;
        apb_paddr = addr; apb_pwdata = wdata;
        @(posedge apb_pclk); #1;
        apb_penable = 1'b1;
        @(negedge apb_pclk);
        rdata = apb_prdata; err = apb_pslverr; rdy = apb_pready;
        @(posedge apb_pclk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic wr_ok(input string name, input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic err, rdy;
        apb_xfer(1'b1, addr, data, rd, err, rdy);
        chk({name, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic err, rdy;
        apb_xfer(1'b0, addr, 32'd0, rd, err, rdy);
        chk(name, rd, exp);
        chk({name, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge apb_pclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err, rdy;

        apb_presetn = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = '0; apb_pwdata = '0; irq_src = '0;

        // Register-level vectors: reset state, RW, masking, decode errors.
        vecs.push_back('{1'b0, 12'h000, 32'h0,        32'h0,  1'b0, "rst_pending"});
        vecs.push_back('{1'b0, 12'h004, 32'h0,        32'h0,  1'b0, "rst_enable"});
        vecs.push_back('{1'b0, 12'h008, 32'h0,        32'h0,  1'b0, "rst_trigger"});
        vecs.push_back('{1'b0, 12'h00C, 32'h0,        32'h0,  1'b0, "rst_claim"});
        vecs.push_back('{1'b0, 12'h010, 32'h0,        32'h0,  1'b0, "rst_ctrl"});
        vecs.push_back('{1'b1, 12'h004, 32'hFFFFFFFF, 32'h0,  1'b0, "wr_enable"});
        vecs.push_back('{1'b0, 12'h004, 32'h0,        32'hFF, 1'b0, "rd_enable_mask"});
        vecs.push_back('{1'b1, 12'h008, 32'h000000A5, 32'h0,  1'b0, "wr_trigger"});
        vecs.push_back('{1'b0, 12'h008, 32'h0,        32'hA5, 1'b0, "rd_trigger"});
        vecs.push_back('{1'b1, 12'h010, 32'hFFFFFFFF, 32'h0,  1'b0, "wr_ctrl"});
        vecs.push_back('{1'b0, 12'h010, 32'h0,        32'h1,  1'b0, "rd_ctrl_bit0"});
        vecs.push_back('{1'b1, 12'h000, 32'hFF,       32'h0,  1'b0, "wr_pending_ro"});
        vecs.push_back('{1'b0, 12'h000, 32'h0,        32'h0,  1'b0, "rd_pending_ro"});
        vecs.push_back('{1'b1, 12'h014, 32'h12345678, 32'h0,  1'b1, "wr_unmapped"});
        vecs.push_back('{1'b0, 12'h014, 32'h0,        32'h0,  1'b1, "rd_unmapped"});
        vecs.push_back('{1'b1, 12'h006, 32'h0,        32'h0,  1'b1, "wr_misaligned"});
        vecs.push_back('{1'b0, 12'h005, 32'h0,        32'h0,  1'b1, "rd_misaligned"});
        vecs.push_back('{1'b0, 12'h004, 32'h0,        32'hFF, 1'b0, "enable_kept"});
        vecs.push_back('{1'b1, 12'h004, 32'h0,        32'h0,  1'b0, "clr_enable"});
        vecs.push_back('{1'b1, 12'h008, 32'h0,        32'h0,  1'b0, "clr_trigger"});
        vecs.push_back('{1'b1, 12'h010, 32'h0,        32'h0,  1'b0, "clr_ctrl"});
        vecs.push_back('{1'b0, 12'h010, 32'h0,        32'h0,  1'b0, "ctrl_cleared"});

        #3;
        chk("rst_irq_out", {31'd0, irq_out}, 32'd0);
        chk("rst_pready", {31'd0, apb_pready}, 32'd0);
        chk("rst_prdata", apb_prdata, 32'd0);
        chk("rst_pslverr", {31'd0, apb_pslverr}, 32'd0);
        cycles(2);
        apb_presetn = 1'b1;
        cycles(1);

        for (int i = 0; i < vecs.size(); i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, rdy);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_slverr"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_pready"}, {31'd0, rdy}, 32'd1);
            chk({vecs[i].name, "_irq_out"}, {31'd0, irq_out}, 32'd0);
        end

        // Setup phase without access phase must not write.
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = 12'h004; apb_pwdata = 32'hFF;
        @(negedge apb_pclk);
        chk("setup_pready", {31'd0, apb_pready}, 32'd0);
        @(posedge apb_pclk); #1;
        apb_psel = 1'b0; apb_pwrite = 1'b0;
        rd_chk("setup_no_write", 12'h004, 32'h0);

        // Edge source 1: two-cycle latency, claim, edge during in-service.
        wr_ok("a_en", 12'h004, 32'h01);
        wr_ok("a_trig", 12'h008, 32'h01);
        wr_ok("a_ctrl", 12'h010, 32'h01);
        irq_src = 8'h01;
        cycles(1);
        irq_src = 8'h00;
        chk("a_irq_lat1", {31'd0, irq_out}, 32'd0);
        cycles(1);
        chk("a_irq_lat2", {31'd0, irq_out}, 32'd1);
        rd_chk("a_pending", 12'h000, 32'h01);
        rd_chk("a_claim", 12'h00C, 32'h01);
        chk("a_irq_claim_edge", {31'd0, irq_out}, 32'd1);
        cycles(1);
        chk("a_irq_dropped", {31'd0, irq_out}, 32'd0);
        rd_chk("a_pending_clr", 12'h000, 32'h00);
        irq_src = 8'h01;
        cycles(1);
        irq_src = 8'h00;
        cycles(1);
        rd_chk("a_edge_in_service", 12'h000, 32'h01);
        wr_ok("a_complete", 12'h00C, 32'h01);
        rd_chk("a_claim2", 12'h00C, 32'h01);
        wr_ok("a_complete2", 12'h00C, 32'h01);
        rd_chk("a_pending_end", 12'h000, 32'h00);

        // Level source 3: no re-pend while in service; bad completes ignored.
        wr_ok("b_trig", 12'h008, 32'h00);
        wr_ok("b_en", 12'h004, 32'h04);
        irq_src = 8'h04;
        cycles(2);
        rd_chk("b_claim", 12'h00C, 32'h03);
        rd_chk("b_pending_in_svc", 12'h000, 32'h00);
        wr_ok("b_complete_11", 12'h00C, 32'd11);
        rd_chk("b_pending_after_11", 12'h000, 32'h00);
        wr_ok("b_complete_9", 12'h00C, 32'd9);
        wr_ok("b_complete_0", 12'h00C, 32'd0);
        rd_chk("b_pending_after_bad", 12'h000, 32'h00);
        wr_ok("b_complete_3", 12'h00C, 32'd3);
        rd_chk("b_pending_repend", 12'h000, 32'h04);
        irq_src = 8'h00;
        rd_chk("b_claim_again", 12'h00C, 32'h03);
        wr_ok("b_complete_again", 12'h00C, 32'd3);
        rd_chk("b_pending_end", 12'h000, 32'h00);

        // Sources 2 and 5 together: lowest ID first.
        wr_ok("c_trig", 12'h008, 32'h12);
        wr_ok("c_en", 12'h004, 32'h12);
        irq_src = 8'h12;
        cycles(1);
        irq_src = 8'h00;
        cycles(1);
        rd_chk("c_pending", 12'h000, 32'h12);
        rd_chk("c_claim_2", 12'h00C, 32'd2);
        rd_chk("c_claim_5", 12'h00C, 32'd5);
        rd_chk("c_claim_none", 12'h00C, 32'd0);
        cycles(1);
        chk("c_irq_off", {31'd0, irq_out}, 32'd0);
        wr_ok("c_complete_2", 12'h00C, 32'd2);
        wr_ok("c_complete_5", 12'h00C, 32'd5);

        // Gating by ENABLE and CTRL; TRIGGER change keeps pending.
        wr_ok("d_trig", 12'h008, 32'h01);
        wr_ok("d_en0", 12'h004, 32'h00);
        irq_src = 8'h01;
        cycles(1);
        irq_src = 8'h00;
        cycles(2);
        chk("d_irq_en_off", {31'd0, irq_out}, 32'd0);
        rd_chk("d_pending_en_off", 12'h000, 32'h01);
        rd_chk("d_claim_masked", 12'h00C, 32'd0);
        wr_ok("d_trig_level", 12'h008, 32'h00);
        rd_chk("d_pending_kept", 12'h000, 32'h01);
        wr_ok("d_en1", 12'h004, 32'h01);
        wr_ok("d_ctrl0", 12'h010, 32'h00);
        cycles(2);
        chk("d_irq_ctrl_off", {31'd0, irq_out}, 32'd0);
        wr_ok("d_ctrl1", 12'h010, 32'h01);
        cycles(1);
        chk("d_irq_on", {31'd0, irq_out}, 32'd1);
        rd_chk("d_claim", 12'h00C, 32'd1);
        wr_ok("d_complete", 12'h00C, 32'd1);
        rd_chk("d_pending_end", 12'h000, 32'h00);

        // Reset asserted mid-transfer with irq_out high.
        wr_ok("e_trig", 12'h008, 32'h01);
        irq_src = 8'h01;
        cycles(1);
        irq_src = 8'h00;
        cycles(1);
        chk("e_irq_before", {31'd0, irq_out}, 32'd1);
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = 12'h004; apb_pwdata = 32'hFF;
        cycles(1);
        apb_penable = 1'b1;
        #2;
        apb_presetn = 1'b0;
        #1;
        chk("e_irq_reset", {31'd0, irq_out}, 32'd0);
        @(posedge apb_pclk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_presetn = 1'b1;
        cycles(1);
        rd_chk("e_enable", 12'h004, 32'h00);
        rd_chk("e_trigger", 12'h008, 32'h00);
        rd_chk("e_ctrl", 12'h010, 32'h00);
        rd_chk("e_pending", 12'h000, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
